router_flit_injector: RTL and testbench

- Network-interface transmitter feeding one router input port; it is the sending end of the 70-bit channel / 3-bit credit interface.
- Accepts packet descriptors and a 64-bit payload stream, then emits head, body and tail flits on the channel.
- Tracks per-VC downstream buffer credits and consumes the credit returns coming back from the router's flow_ctrl_out_ip port.

---
 rtl/noc_flit_pkg.sv | 34 +++
 rtl/noc_credit_counter.sv | 35 +++
 rtl/router_flit_injector.sv | 141 ++++++++++++++
 tb/tb_router_flit_injector.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_flit_pkg.sv
// Shared field map, widths and FSM encoding for the NoC flit channel and
// its 3-bit credit-return interface.
package noc_flit_pkg;

    localparam int CHANNEL_W   = 70;
    localparam int FLOW_CTRL_W = 3;
    localparam int FLIT_DATA_W = 64;
    localparam int MAX_VCS     = 4;

    localparam int FLIT_VALID    = 0;
    localparam int FLIT_HEAD     = 1;
    localparam int FLIT_TAIL     = 2;
    localparam int FLIT_VC_LSB   = 3;
    localparam int FLIT_VC_MSB   = 4;
    localparam int FLIT_RSV      = 5;
    localparam int FLIT_DATA_LSB = 6;
    localparam int FLIT_DATA_MSB = 69;

    // Head-flit fields, given as absolute channel bit positions.
    localparam int HDR_DEST_LSB = 6;
    localparam int HDR_SRC_LSB  = 10;
    localparam int HDR_LEN_LSB  = 14;

    localparam int FC_VALID  = 0;
    localparam int FC_VC_LSB = 1;
    localparam int FC_VC_MSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY
    } inj_state_e;

endpackage

// File: rtl/noc_credit_counter.sv
// Per-VC downstream buffer credit counter; starts full, saturates at BUF_DEPTH
// and pulses overflow when a return arrives with the count already full.
module noc_credit_counter #(
    parameter int BUF_DEPTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic has_credit,
    output logic overflow
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d  = count_q;
        overflow = 1'b0;
        if (inc && !dec) begin
            if (count_q == CW'(BUF_DEPTH)) overflow = 1'b1;
            else                           count_d  = count_q + 1'b1;
        end else if (dec && !inc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= CW'(BUF_DEPTH);
        else       count_q <= count_d;
    end

    assign has_credit = (count_q != '0);

endmodule

// File: rtl/router_flit_injector.sv
// NoC network-interface transmitter: turns descriptors plus payload words into
// credit-gated head/body/tail flits. Define FLIT_INJ_PARITY_EN for data parity in bit 5.
module router_flit_injector
    import noc_flit_pkg::*;
#(
    parameter int NUM_VCS   = 4,
    parameter int BUF_DEPTH = 8,
    parameter int LEN_W     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             router_address,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic [3:0]             pkt_dest,
    input  logic [1:0]             pkt_vc,
    input  logic [LEN_W-1:0]       pkt_len,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [FLIT_DATA_W-1:0] data,
    output logic [CHANNEL_W-1:0]   channel_out,
    input  logic [FLOW_CTRL_W-1:0] flow_ctrl_in,
    output logic                   error
);
    localparam int DEST_OFS = HDR_DEST_LSB - FLIT_DATA_LSB;
    localparam int SRC_OFS  = HDR_SRC_LSB - FLIT_DATA_LSB;
    localparam int LEN_OFS  = HDR_LEN_LSB - FLIT_DATA_LSB;

    inj_state_e             state_q;
    logic [CHANNEL_W-1:0]   chan_q;
    logic                   error_q;
    logic [3:0]             dest_q;
    logic [1:0]             vc_q;
    logic [LEN_W-1:0]       len_q, rem_q;
    logic [1:0]             vc_sel;
    logic [FLIT_DATA_W-1:0] hdr_payload;
    logic [MAX_VCS-1:0]     has_credit, inc, dec, ovf;
    logic                   send_head, send_body;

    function automatic logic [CHANNEL_W-1:0] make_flit(
        input logic                   head,
        input logic                   tail,
        input logic [1:0]             vc,
        input logic [FLIT_DATA_W-1:0] payload
    );
        logic [CHANNEL_W-1:0] f;
        f = '0;
        f[FLIT_VALID]                  = 1'b1;
        f[FLIT_HEAD]                   = head;
        f[FLIT_TAIL]                   = tail;
        f[FLIT_VC_MSB:FLIT_VC_LSB]     = vc;
        f[FLIT_DATA_MSB:FLIT_DATA_LSB] = payload;
`ifdef FLIT_INJ_PARITY_EN
        f[FLIT_RSV] = ^payload;
`endif
        return f;
    endfunction

    assign vc_sel = 2'(int'(pkt_vc) % NUM_VCS);

    always_comb begin
        hdr_payload                    = '0;
        hdr_payload[DEST_OFS +: 4]     = dest_q;
        hdr_payload[SRC_OFS +: 4]      = router_address;
        hdr_payload[LEN_OFS +: LEN_W]  = len_q;
    end

    // Unused VC slots are tied off so the 2-bit VC can index the vectors directly.
    for (genvar v = 0; v < MAX_VCS; v++) begin : g_vc
        if (v < NUM_VCS) begin : g_cnt
            assign inc[v] = flow_ctrl_in[FC_VALID] &&
                            (flow_ctrl_in[FC_VC_MSB:FC_VC_LSB] == 2'(v));
            assign dec[v] = (send_head || send_body) && (vc_q == 2'(v));
            noc_credit_counter #(.BUF_DEPTH(BUF_DEPTH)) u_cnt (
                .clk        (clk),
                .reset      (reset),
                .inc        (inc[v]),
                .dec        (dec[v]),
                .has_credit (has_credit[v]),
                .overflow   (ovf[v])
            );
        end else begin : g_none
            assign inc[v]        = 1'b0;
            assign dec[v]        = 1'b0;
            assign has_credit[v] = 1'b0;
            assign ovf[v]        = 1'b0;
        end
    end

    assign send_head  = (state_q == ST_HEAD) && has_credit[vc_q];
    assign data_ready = (state_q == ST_BODY) && has_credit[vc_q];
    assign send_body  = data_ready && data_valid;
    assign pkt_ready  = (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            rem_q   <= '0;
            error_q <= 1'b0;
        end else begin
            chan_q <= '0;
            if (|ovf) error_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (pkt_valid) begin
                        rem_q   <= pkt_len;
                        state_q <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (send_head) begin
                        chan_q  <= make_flit(1'b1, len_q == '0, vc_q, hdr_payload);
                        state_q <= (len_q == '0) ? ST_IDLE : ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (send_body) begin
                        chan_q <= make_flit(1'b0, rem_q == LEN_W'(1), vc_q, data);
                        rem_q  <= rem_q - 1'b1;
                        if (rem_q == LEN_W'(1)) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Descriptor fields only matter once a packet is accepted, so they need no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && pkt_valid) begin
            dest_q <= pkt_dest;
            vc_q   <= vc_sel;
            len_q  <= pkt_len;
        end
    end

    assign channel_out = chan_q;
    assign error       = error_q;

endmodule

// File: tb/tb_router_flit_injector.sv
// Self-checking bench for router_flit_injector: directed vectors, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_router_flit_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  router_address;
    logic        pkt_valid;
    logic [3:0]  pkt_dest;
    logic [1:0]  pkt_vc;
    logic [3:0]  pkt_len;
    logic        data_valid;
    logic [63:0] data;
    logic [2:0]  flow_ctrl_in;
    logic        pkt_ready, data_ready, error;
    logic [69:0] channel_out;

    int total = 0;
    int bad   = 0;

`ifdef FLIT_INJ_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    router_flit_injector dut (
        .clk            (clk),
        .reset          (reset),
        .router_address (router_address),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_dest       (pkt_dest),
        .pkt_vc         (pkt_vc),
        .pkt_len        (pkt_len),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .data           (data),
        .channel_out    (channel_out),
        .flow_ctrl_in   (flow_ctrl_in),
        .error          (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dest;
        logic [1:0]  vc;
        logic [3:0]  src;
        logic [69:0] exp;
    } vec_t;

    vec_t tbl[4];

    task automatic chkv(input string nm, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Expected flit from the channel field map.
    function automatic logic [69:0] mk(input bit head, input bit tail,
                                       input logic [1:0] vc, input logic [63:0] d);
        logic [69:0] f;
        f = {d, 1'b0, vc, tail, head, 1'b1};
        if (PAR_ON) f[5] = ^d;
        return f;
    endfunction

    function automatic logic [63:0] hdr(input logic [3:0] dest, input logic [3:0] src,
                                        input logic [3:0] len);
        return {52'd0, len, src, dest};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pkt_valid    = 1'b0;
        data_valid   = 1'b0;
        flow_ctrl_in = 3'b000;
        pkt_dest     = 4'd0;
        pkt_vc       = 2'd0;
        pkt_len      = 4'd0;
        data         = 64'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Starts a packet with data always valid and counts flits over ncyc cycles.
    task automatic run_pkt_count(input logic [1:0] vc, input logic [3:0] len,
                                 input int ncyc, output int nfl);
        nfl        = 0;
        pkt_dest   = 4'h2;
        pkt_vc     = vc;
        pkt_len    = len;
        pkt_valid  = 1'b1;
        data_valid = 1'b1;
        data       = 64'h55;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            pkt_valid = 1'b0;
            if (channel_out[0]) nfl++;
            data = data + 64'd1;
        end
    endtask

    // Random-phase model state
    int          cred[4];
    bit          busy, in_body, exp_err;
    logic [1:0]  cur_vc;
    int          cur_len, nbody;
    logic [69:0] expq[$];

    initial begin
        int          n;
        bit          phs, dhs;
        logic [2:0]  ret;
        logic [1:0]  v;
        logic [69:0] e;

        tbl[0] = '{dest: 4'd5, vc: 2'd1, src: 4'd3, exp: '0};
        tbl[1] = '{dest: 4'hA, vc: 2'd0, src: 4'hF, exp: '0};
        tbl[2] = '{dest: 4'hF, vc: 2'd3, src: 4'h0, exp: '0};
        tbl[3] = '{dest: 4'd6, vc: 2'd2, src: 4'd9, exp: '0};
        for (int i = 0; i < 4; i++)
            tbl[i].exp = mk(1'b1, 1'b1, tbl[i].vc, hdr(tbl[i].dest, tbl[i].src, 4'd0));

        router_address = 4'd3;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chkv("reset_channel", channel_out, 70'd0);
        chk1("reset_pkt_ready", pkt_ready, 1'b1);
        chk1("reset_data_ready", data_ready, 1'b0);
        chk1("reset_error", error, 1'b0);
        reset = 1'b0;
        tick();

        // Head-only packets from the vector table
        for (int i = 0; i < 4; i++) begin
            router_address = tbl[i].src;
            pkt_dest  = tbl[i].dest;
            pkt_vc    = tbl[i].vc;
            pkt_len   = 4'd0;
            pkt_valid = 1'b1;
            tick();
            pkt_valid = 1'b0;
            chkv("tbl_no_flit_at_accept", channel_out, 70'd0);
            chk1("tbl_busy", pkt_ready, 1'b0);
            tick();
            chkv("tbl_head_flit", channel_out, tbl[i].exp);
            chk1("tbl_ready_again", pkt_ready, 1'b1);
            tick();
            chkv("tbl_single_cycle", channel_out, 70'd0);
        end

        // len=3 on vc 0, data A/B/C back to back
        router_address = 4'd3;
        pkt_dest = 4'd9; pkt_vc = 2'd0; pkt_len = 4'd3; pkt_valid = 1'b1;
        data_valid = 1'b1; data = 64'hA;
        tick();
        pkt_valid = 1'b0;
        chk1("l3_pkt_ready_low", pkt_ready, 1'b0);
        chkv("l3_nothing_yet", channel_out, 70'd0);
        tick();
        chkv("l3_head", channel_out, mk(1'b1, 1'b0, 2'd0, hdr(4'd9, 4'd3, 4'd3)));
        tick();
        chkv("l3_body_a", channel_out, mk(1'b0, 1'b0, 2'd0, 64'hA));
        data = 64'hB;
        tick();
        chkv("l3_body_b", channel_out, mk(1'b0, 1'b0, 2'd0, 64'hB));
        data = 64'hC;
        tick();
        chkv("l3_tail_c", channel_out, mk(1'b0, 1'b1, 2'd0, 64'hC));
        chk1("l3_pkt_ready_back", pkt_ready, 1'b1);
        data_valid = 1'b0;
        tick();
        chkv("l3_idle_after", channel_out, 70'd0);

        // Reserved bit behaviour
        pkt_dest = 4'd7; pkt_vc = 2'd1; pkt_len = 4'd2; pkt_valid = 1'b1;
        data_valid = 1'b1; data = 64'h1;
        tick();
        pkt_valid = 1'b0;
        tick();
        tick();
        chk1("par_data1_bit5", channel_out[5], PAR_ON);
        chkv("par_data1_flit", channel_out, mk(1'b0, 1'b0, 2'd1, 64'h1));
        data = 64'h3;
        tick();
        chk1("par_data3_bit5", channel_out[5], 1'b0);
        chkv("par_data3_flit", channel_out, mk(1'b0, 1'b1, 2'd1, 64'h3));
        data_valid = 1'b0;

        // Credit exhaustion on vc 2, then release with one return
        do_reset();
        run_pkt_count(2'd2, 4'd9, 20, n);
        chkv("exh_flits_before_stall", 70'(n), 70'd8);
        chk1("exh_data_ready_low", data_ready, 1'b0);
        flow_ctrl_in = {2'd2, 1'b1};
        tick();
        chk1("exh_ready_after_return", data_ready, 1'b1);
        chk1("exh_no_flit_on_return", channel_out[0], 1'b0);
        tick();
        flow_ctrl_in = 3'b000;
        chk1("exh_ninth_flit", channel_out[0], 1'b1);
        chk1("simul_count_unchanged", data_ready, 1'b1);
        tick();
        chkv("exh_tail", channel_out[2:0], 70'(3'b101));
        chk1("exh_pkt_ready", pkt_ready, 1'b1);
        data_valid = 1'b0;

        // Overflow: return at full count
        do_reset();
        flow_ctrl_in = {2'd0, 1'b1};
        tick();
        flow_ctrl_in = 3'b000;
        chk1("ovf_error_set", error, 1'b1);
        tick();
        tick();
        chk1("ovf_error_sticky", error, 1'b1);
        run_pkt_count(2'd0, 4'd9, 20, n);
        chkv("ovf_count_saturated", 70'(n), 70'd8);
        chk1("ovf_error_still", error, 1'b1);

        // Reset in the middle of a body
        do_reset();
        pkt_dest = 4'd4; pkt_vc = 2'd3; pkt_len = 4'd5; pkt_valid = 1'b1;
        data_valid = 1'b1; data = 64'hDEAD;
        tick();
        pkt_valid = 1'b0;
        tick();
        tick();
        tick();
        chk1("mid_in_body", channel_out[0], 1'b1);
        #2 reset = 1'b1;
        #1;
        chkv("mid_reset_channel", channel_out, 70'd0);
        chk1("mid_reset_pkt_ready", pkt_ready, 1'b1);
        chk1("mid_reset_data_ready", data_ready, 1'b0);
        idle_inputs();
        tick();
        reset = 1'b0;
        run_pkt_count(2'd3, 4'd9, 20, n);
        chkv("mid_credits_restored", 70'(n), 70'd8);

        // Randomized run against the transaction-level model
        do_reset();
        router_address = 4'($urandom);
        for (int i = 0; i < 4; i++) cred[i] = 8;
        busy = 0; in_body = 0; exp_err = 0; cur_vc = 2'd0; cur_len = 0; nbody = 0;
        expq.delete();
        for (int c = 0; c < 3000; c++) begin
            chk1("rnd_pkt_ready", pkt_ready, !busy);
            chk1("rnd_data_ready", data_ready, in_body && (cred[cur_vc] > 0));
            chk1("rnd_error", error, exp_err);
            phs = pkt_valid && pkt_ready;
            dhs = data_valid && data_ready;
            if (phs) begin
                busy    = 1;
                cur_vc  = pkt_vc;
                cur_len = int'(pkt_len);
                nbody   = 0;
                expq.push_back(mk(1'b1, pkt_len == 4'd0, pkt_vc,
                                  hdr(pkt_dest, router_address, pkt_len)));
            end
            if (dhs) begin
                nbody++;
                expq.push_back(mk(1'b0, nbody == cur_len, cur_vc, data));
            end
            ret = flow_ctrl_in;
            tick();
            if (channel_out[0]) begin
                if (expq.size() == 0) begin
                    chkv("rnd_unexpected_flit", channel_out, 70'd0);
                end else begin
                    e = expq.pop_front();
                    chkv("rnd_flit", channel_out, e);
                end
                v = channel_out[4:3];
                chk1("rnd_credit_available", cred[v] > 0, 1'b1);
                if (cred[v] > 0) cred[v]--;
                if (channel_out[1] && !channel_out[2]) in_body = 1;
                if (channel_out[2]) begin
                    in_body = 0;
                    busy    = 0;
                end
            end
            if (ret[0]) begin
                if (cred[ret[2:1]] >= 8) exp_err = 1;
                else                     cred[ret[2:1]]++;
            end
            if (phs || !pkt_valid) begin
                pkt_valid = (c < 2700) && ($urandom_range(0, 2) == 0);
                pkt_dest  = 4'($urandom);
                pkt_vc    = 2'($urandom);
                pkt_len   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            end
            if (dhs || !data_valid) begin
                data_valid = ($urandom_range(0, 9) < 7);
                data       = {$urandom, $urandom};
            end
            v = 2'($urandom);
            if ($urandom_range(0, 1) == 1 && cred[v] < 8) flow_ctrl_in = {v, 1'b1};
            else                                           flow_ctrl_in = 3'b000;
        end
        chk1("rnd_all_flits_sent", (expq.size() == 0) && !busy, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
